// File: rtl/blob_bbox_extract.sv
// Streaming bounding-box extractor for up to 16 foreground objects.
// Each mask pixel joins the lowest-indexed open box that lies within MARGIN
// of it, or opens a new box. Once per frame the box table, an object count
// and an overflow flag are published.
// Ports:
//   sys_clk, sys_rst    pixel clock, synchronous active-high reset
//   bin_wr_en           pixel strobe, one raster-order mask pixel per cycle
//   bin_hs              line sync (not used)
//   bin_vs              frame sync; its rising edge restarts the frame
//   bin_data            mask pixel, 1 = foreground
//   pos_data[k]         {flag, ymax, xmax, ymin, xmin} for slot k
//   pos_valid           one-cycle pulse when a table is published
//   obj_num             number of flags set in the published table
//   overflow            the published frame needed more than 16 boxes
module blob_bbox_extract #(
  parameter int unsigned H_PIXEL = 1024,
  parameter int unsigned V_PIXEL = 768,
  parameter int unsigned MARGIN  = 8,
  parameter int unsigned MIN_W   = 4,
  parameter int unsigned MIN_H   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bin_wr_en,
  input  logic              bin_hs,
  input  logic              bin_vs,
  input  logic              bin_data,
  output logic [15:0][42:0] pos_data,
  output logic              pos_valid,
  output logic [4:0]        obj_num,
  output logic              overflow
);

  localparam int unsigned NSLOT = 16;
  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;
  localparam int unsigned CW    = 12;
  localparam int unsigned IW    = 4;
  localparam int unsigned NW    = 5;
  localparam int unsigned DW    = 43;

  // Working box table
  logic [NSLOT-1:0] valid_q, valid_d;
  logic [XW-1:0]    xmin_q [NSLOT];
  logic [XW-1:0]    xmin_d [NSLOT];
  logic [XW-1:0]    xmax_q [NSLOT];
  logic [XW-1:0]    xmax_d [NSLOT];
  logic [YW-1:0]    ymin_q [NSLOT];
  logic [YW-1:0]    ymin_d [NSLOT];
  logic [YW-1:0]    ymax_q [NSLOT];
  logic [YW-1:0]    ymax_d [NSLOT];
  logic             ovf_q, ovf_d;

  logic [XW-1:0]    cnt_x_q, cnt_x_d;
  logic [YW-1:0]    cnt_y_q, cnt_y_d;
  logic             vs_q;

  logic             vs_rise;
  logic             last_pix;
  logic [NSLOT-1:0] match;
  logic [IW-1:0]    hit_idx;
  logic [IW-1:0]    free_idx;
  logic [NSLOT-1:0] flag;
  logic [15:0][42:0] pub_data;
  logic [NW-1:0]    pub_num;

  logic unused_hs;
  assign unused_hs = bin_hs;

  assign vs_rise  = bin_vs && !vs_q;
  assign last_pix = bin_wr_en && (cnt_x_q == XW'(H_PIXEL - 1))
                              && (cnt_y_q == YW'(V_PIXEL - 1));

  // Adjacency match against every open box; widened so x-MARGIN cannot wrap
  always_comb begin
    match    = '0;
    hit_idx  = '0;
    free_idx = '0;
    for (int k = 0; k < int'(NSLOT); k++) begin
      match[k] = valid_q[k]
              && (CW'(cnt_x_q) + CW'(MARGIN) >= CW'(xmin_q[k]))
              && (CW'(cnt_x_q) <= CW'(xmax_q[k]) + CW'(MARGIN))
              && (CW'(cnt_y_q) <= CW'(ymax_q[k]) + CW'(MARGIN));
    end
    // Descending scan so the lowest index is the one left standing
    for (int k = int'(NSLOT) - 1; k >= 0; k--) begin
      if (match[k])    hit_idx  = IW'(k);
      if (!valid_q[k]) free_idx = IW'(k);
    end
  end

  // Working table next state: clear on frame restart/publish, else grow or allocate
  always_comb begin
    valid_d = valid_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    ovf_d   = ovf_q;
    if (vs_rise || last_pix) begin
      valid_d = '0;
      xmin_d  = '{default: '0};
      xmax_d  = '{default: '0};
      ymin_d  = '{default: '0};
      ymax_d  = '{default: '0};
      ovf_d   = 1'b0;
    end else if (bin_wr_en && bin_data) begin
      if (|match) begin
        if (cnt_x_q < xmin_q[hit_idx]) xmin_d[hit_idx] = cnt_x_q;
        if (cnt_x_q > xmax_q[hit_idx]) xmax_d[hit_idx] = cnt_x_q;
        ymax_d[hit_idx] = cnt_y_q;
      end else if (!(&valid_q)) begin
        valid_d[free_idx] = 1'b1;
        xmin_d[free_idx]  = cnt_x_q;
        xmax_d[free_idx]  = cnt_x_q;
        ymin_d[free_idx]  = cnt_y_q;
        ymax_d[free_idx]  = cnt_y_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Raster position counters
  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (vs_rise) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (bin_wr_en) begin
      if (cnt_x_q == XW'(H_PIXEL - 1)) begin
        cnt_x_d = '0;
        cnt_y_d = (cnt_y_q == YW'(V_PIXEL - 1)) ? '0 : cnt_y_q + YW'(1);
      end else begin
        cnt_x_d = cnt_x_q + XW'(1);
      end
    end
  end

  // Publish image of the table: size-qualified flags, invalid slots zeroed
  always_comb begin
    flag     = '0;
    pub_data = '0;
    pub_num  = '0;
    for (int k = 0; k < int'(NSLOT); k++) begin
      flag[k] = valid_q[k]
             && (CW'(xmax_q[k]) - CW'(xmin_q[k]) + CW'(1) >= CW'(MIN_W))
             && (CW'(ymax_q[k]) - CW'(ymin_q[k]) + CW'(1) >= CW'(MIN_H));
      if (valid_q[k]) begin
        pub_data[k] = DW'({flag[k], ymax_q[k], xmax_q[k], ymin_q[k], xmin_q[k]});
      end
      pub_num = pub_num + NW'(flag[k]);
    end
  end

  // State registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      valid_q <= '0;
      xmin_q  <= '{default: '0};
      xmax_q  <= '{default: '0};
      ymin_q  <= '{default: '0};
      ymax_q  <= '{default: '0};
      ovf_q   <= 1'b0;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      vs_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      ovf_q   <= ovf_d;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      vs_q    <= bin_vs;
    end
  end

  // Published outputs hold until the next publish
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pos_data  <= '0;
      pos_valid <= 1'b0;
      obj_num   <= '0;
      overflow  <= 1'b0;
    end else begin
      pos_valid <= last_pix;
      if (last_pix) begin
        pos_data <= pub_data;
        obj_num  <= pub_num;
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_blob_bbox_extract.sv
// Self-checking bench for blob_bbox_extract on a 64x48 raster, MARGIN=2.
// Frames are painted from rectangle lists; expected tables are derived from
// the rectangles and queued, publishes are captured and compared per test.
module tb_blob_bbox_extract;

  localparam int H = 64;
  localparam int V = 48;

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
  } rect_t;

  typedef struct {
    logic [15:0][42:0] data;
    logic [4:0]        num;
    logic              ovf;
  } pub_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              bin_wr_en;
  logic              bin_hs;
  logic              bin_vs;
  logic              bin_data;
  logic [15:0][42:0] pos_data;
  logic              pos_valid;
  logic [4:0]        obj_num;
  logic              overflow;

  rect_t cur_rects[$];
  pub_t  exp_q[$];
  pub_t  got_q[$];
  int    n_run  = 0;
  int    n_fail = 0;

  blob_bbox_extract #(
    .H_PIXEL(H), .V_PIXEL(V), .MARGIN(2), .MIN_W(4), .MIN_H(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bin_wr_en(bin_wr_en),
    .bin_hs   (bin_hs),
    .bin_vs   (bin_vs),
    .bin_data (bin_data),
    .pos_data (pos_data),
    .pos_valid(pos_valid),
    .obj_num  (obj_num),
    .overflow (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  // Advance one clock, sample just after the edge, capture any publish
  task automatic tick();
    pub_t g;
    @(posedge sys_clk);
    #1;
    if (pos_valid === 1'b1) begin
      g.data = pos_data;
      g.num  = obj_num;
      g.ovf  = overflow;
      got_q.push_back(g);
    end
  endtask

  function automatic bit in_blob(input int x, input int y);
    bit hit = 1'b0;
    foreach (cur_rects[i]) begin
      if (x >= cur_rects[i].x0 && x <= cur_rects[i].x1 &&
          y >= cur_rects[i].y0 && y <= cur_rects[i].y1) hit = 1'b1;
    end
    return hit;
  endfunction

  // Well-separated rectangles listed in raster order of their first pixel
  // each fill one slot in order; beyond 16 they are lost and flag overflow.
  function automatic pub_t model();
    pub_t p;
    bit   f;
    p.data = '0;
    p.num  = '0;
    p.ovf  = 1'b0;
    foreach (cur_rects[i]) begin
      if (i < 16) begin
        f = (cur_rects[i].x1 - cur_rects[i].x0 + 1 >= 4) &&
            (cur_rects[i].y1 - cur_rects[i].y0 + 1 >= 4);
        p.data[i] = {f, 10'(cur_rects[i].y1), 11'(cur_rects[i].x1),
                        10'(cur_rects[i].y0), 11'(cur_rects[i].x0)};
        if (f) p.num = p.num + 5'd1;
      end else begin
        p.ovf = 1'b1;
      end
    end
    return p;
  endfunction

  task automatic drive_pixels(input int lines, input int extra, input bit gaps);
    for (int y = 0; y <= lines; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y == lines && x >= extra) break;
        if (gaps && $urandom_range(0, 7) == 0) begin
          bin_wr_en = 1'b0;
          bin_data  = 1'($urandom_range(0, 1));
          tick();
        end
        bin_wr_en = 1'b1;
        bin_data  = in_blob(x, y);
        tick();
      end
    end
    bin_wr_en = 1'b0;
    bin_data  = 1'b0;
  endtask

  task automatic run_frame(input bit with_vs, input bit gaps);
    if (with_vs) begin
      bin_vs = 1'b1;
      tick();
      bin_vs = 1'b0;
      tick();
    end
    exp_q.push_back(model());
    drive_pixels(V, 0, gaps);
    tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    n_run++;
    if (pos_data !== '0) begin
      n_fail++; $display("FAIL reset_pos_data: got %h expected 0", pos_data);
    end
    n_run++;
    if (pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_pos_valid: got %b expected 0", pos_valid);
    end
    n_run++;
    if (obj_num !== 5'd0) begin
      n_fail++; $display("FAIL reset_obj_num: got %0d expected 0", obj_num);
    end
    n_run++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_blob();
    pub_t g, e;
    cur_rects = '{'{20, 10, 29, 15}};
    run_frame(1'b1, 1'b0);
    n_run++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL single_publish_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_run++;
      if (g.data !== e.data) begin
        n_fail++; $display("FAIL single_pos_data: got %h expected %h", g.data, e.data);
      end
      n_run++;
      if (g.num !== e.num) begin
        n_fail++; $display("FAIL single_obj_num: got %0d expected %0d", g.num, e.num);
      end
      n_run++;
      if (g.ovf !== e.ovf) begin
        n_fail++; $display("FAIL single_overflow: got %b expected %b", g.ovf, e.ovf);
      end
      repeat (5) tick();
      n_run++;
      if (pos_data !== e.data || obj_num !== e.num || pos_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_hold: got %h/%0d/%b expected %h/%0d/0",
                           pos_data, obj_num, pos_valid, e.data, e.num);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_two_blobs_with_gaps();
    pub_t g, e;
    cur_rects = '{'{5, 5, 9, 9}, '{40, 20, 49, 30}};
    run_frame(1'b1, 1'b1);
    n_run++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL two_publish_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_run++;
      if (g.data !== e.data) begin
        n_fail++; $display("FAIL two_pos_data: got %h expected %h", g.data, e.data);
      end
      n_run++;
      if (g.num !== e.num) begin
        n_fail++; $display("FAIL two_obj_num: got %0d expected %0d", g.num, e.num);
      end
      n_run++;
      if (g.ovf !== e.ovf) begin
        n_fail++; $display("FAIL two_overflow: got %b expected %b", g.ovf, e.ovf);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    pub_t g, e;
    cur_rects.delete();
    for (int b = 0; b < 17; b++) begin
      cur_rects.push_back('{2 + 8 * (b % 8), 2 + 10 * (b / 8),
                            5 + 8 * (b % 8), 5 + 10 * (b / 8)});
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) cur_rects.delete();
      run_frame(1'b1, 1'b0);
      n_run++;
      if (got_q.size() != 1) begin
        n_fail++; $display("FAIL ovf%0d_publish_count: got %0d expected 1", f, got_q.size());
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        n_run++;
        if (g.data !== e.data) begin
          n_fail++; $display("FAIL ovf%0d_pos_data: got %h expected %h", f, g.data, e.data);
        end
        n_run++;
        if (g.num !== e.num) begin
          n_fail++; $display("FAIL ovf%0d_obj_num: got %0d expected %0d", f, g.num, e.num);
        end
        n_run++;
        if (g.ovf !== e.ovf) begin
          n_fail++; $display("FAIL ovf%0d_overflow: got %b expected %b", f, g.ovf, e.ovf);
        end
      end
      got_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_min_size();
    pub_t g, e;
    cur_rects = '{'{10, 10, 11, 11}, '{30, 20, 35, 25}};
    run_frame(1'b1, 1'b0);
    n_run++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL minsize_publish_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_run++;
      if (g.data !== e.data) begin
        n_fail++; $display("FAIL minsize_pos_data: got %h expected %h", g.data, e.data);
      end
      n_run++;
      if (g.num !== e.num) begin
        n_fail++; $display("FAIL minsize_obj_num: got %0d expected %0d", g.num, e.num);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_resync();
    pub_t g, e;
    cur_rects = '{'{3, 5, 9, 8}};
    drive_pixels(20, 5, 1'b0);
    bin_vs = 1'b1;
    tick();
    n_run++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL resync_no_publish: got %0d publishes expected 0", got_q.size());
    end
    got_q.delete();
    bin_vs = 1'b0;
    tick();
    cur_rects = '{'{50, 30, 55, 35}};
    run_frame(1'b0, 1'b0);
    n_run++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL resync_publish_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_run++;
      if (g.data !== e.data) begin
        n_fail++; $display("FAIL resync_pos_data: got %h expected %h", g.data, e.data);
      end
      n_run++;
      if (g.num !== e.num) begin
        n_fail++; $display("FAIL resync_obj_num: got %0d expected %0d", g.num, e.num);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    pub_t g, e;
    cur_rects = '{'{3, 2, 12, 6}};
    drive_pixels(10, 3, 1'b0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_run++;
    if (pos_data !== '0 || obj_num !== 5'd0 || overflow !== 1'b0 || pos_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h/%0d/%b/%b expected all 0",
                         pos_data, obj_num, overflow, pos_valid);
    end
    n_run++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_no_publish: got %0d publishes expected 0", got_q.size());
    end
    got_q.delete();
    cur_rects = '{'{15, 40, 22, 44}};
    run_frame(1'b0, 1'b0);
    n_run++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_publish_count: got %0d expected 1", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_run++;
      if (g.data !== e.data) begin
        n_fail++; $display("FAIL midrst_pos_data: got %h expected %h", g.data, e.data);
      end
      n_run++;
      if (g.num !== e.num) begin
        n_fail++; $display("FAIL midrst_obj_num: got %0d expected %0d", g.num, e.num);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    sys_rst   = 1'b1;
    bin_wr_en = 1'b0;
    bin_hs    = 1'b0;
    bin_vs    = 1'b0;
    bin_data  = 1'b0;
    test_reset();
    test_single_blob();
    test_two_blobs_with_gaps();
    test_overflow();
    test_min_size();
    test_resync();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
